// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: turns the selected run rate, a debounced step
// button or hold into single-cycle cpu_en strobes, switching modes only at strobe boundaries.
module cpu_clk_ctrl #(
    parameter int unsigned FAST_DIV   = 4,
    parameter int unsigned SLOW_DIV   = 33554432,
    parameter int unsigned DEB_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic        step_btn,
    output logic        cpu_en,
    output logic [1:0]  mode_cur,
    output logic        pending,
    output logic [31:0] tick_cnt
);

    localparam logic [1:0] MODE_FAST = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam int unsigned     DEB_W     = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 32'd1);
    localparam logic [31:0]     FAST_LAST = 32'(FAST_DIV - 32'd1);
    localparam logic [31:0]     SLOW_LAST = 32'(SLOW_DIV - 32'd1);

    logic [1:0]       mode_s1_r;
    logic [1:0]       mode_req_r;
    logic [1:0]       sync_vld_r;
    logic             btn_s1_r;
    logic             btn_sync_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic             deb_lvl_r;
    logic             deb_rise_r;
    logic [31:0]      presc_r;
    logic             cpu_en_r;
    logic [1:0]       mode_cur_r;
    logic             pending_r;
    logic [31:0]      tick_cnt_r;

    logic             change_s;
    logic [31:0]      presc_last_s;
    logic [DEB_W-1:0] deb_cnt_nxt_s;
    logic             deb_lvl_nxt_s;
    logic             deb_rise_nxt_s;
    logic [31:0]      presc_nxt_s;
    logic             cpu_en_nxt_s;
    logic [1:0]       mode_nxt_s;

    // A cleared mode chain reads as a fast request, so it is ignored until two real samples have arrived.
    assign change_s     = sync_vld_r[1] && (mode_req_r != mode_cur_r);
    assign presc_last_s = mode_cur_r[0] ? SLOW_LAST : FAST_LAST;

    // Two-flop synchronizers for the mode request and the push-button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_s1_r  <= 2'b00;
            mode_req_r <= 2'b00;
            sync_vld_r <= 2'b00;
            btn_s1_r   <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            mode_s1_r  <= mode;
            mode_req_r <= mode_s1_r;
            sync_vld_r <= {sync_vld_r[0], 1'b1};
            btn_s1_r   <= step_btn;
            btn_sync_r <= btn_s1_r;
        end
    end

    // Debounce: a differing level must persist DEB_CYCLES samples before it is accepted.
    always_comb begin
        deb_cnt_nxt_s  = deb_cnt_r;
        deb_lvl_nxt_s  = deb_lvl_r;
        deb_rise_nxt_s = 1'b0;
        if (btn_sync_r == deb_lvl_r) begin
            deb_cnt_nxt_s = '0;
        end else if (deb_cnt_r == DEB_LAST) begin
            deb_cnt_nxt_s  = '0;
            deb_lvl_nxt_s  = ~deb_lvl_r;
            deb_rise_nxt_s = ~deb_lvl_r;
        end else begin
            deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt_r  <= '0;
            deb_lvl_r  <= 1'b0;
            deb_rise_r <= 1'b0;
        end else begin
            deb_cnt_r  <= deb_cnt_nxt_s;
            deb_lvl_r  <= deb_lvl_nxt_s;
            deb_rise_r <= deb_rise_nxt_s;
        end
    end

    // Strobe generation and mode apply; run modes switch only on the strobe edge.
    always_comb begin
        presc_nxt_s  = 32'd0;
        cpu_en_nxt_s = 1'b0;
        mode_nxt_s   = mode_cur_r;
        case (mode_cur_r)
            MODE_FAST, MODE_SLOW: begin
                if (presc_r == presc_last_s) begin
                    cpu_en_nxt_s = 1'b1;
                    presc_nxt_s  = 32'd0;
                    if (change_s) begin
                        mode_nxt_s = mode_req_r;
                    end else begin
                        mode_nxt_s = mode_cur_r;
                    end
                end else begin
                    presc_nxt_s = presc_r + 32'd1;
                end
            end
            MODE_STEP: begin
                // A pending mode change beats a simultaneous button edge.
                if (change_s) begin
                    mode_nxt_s = mode_req_r;
                end else if (deb_rise_r && !cpu_en_r) begin
                    cpu_en_nxt_s = 1'b1;
                end else begin
                    cpu_en_nxt_s = 1'b0;
                end
            end
            MODE_HOLD: begin
                if (change_s) begin
                    mode_nxt_s = mode_req_r;
                end else begin
                    mode_nxt_s = mode_cur_r;
                end
            end
            default: begin
                mode_nxt_s = MODE_HOLD;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r    <= 32'd0;
            cpu_en_r   <= 1'b0;
            mode_cur_r <= MODE_HOLD;
            pending_r  <= 1'b0;
            tick_cnt_r <= 32'd0;
        end else begin
            presc_r    <= presc_nxt_s;
            cpu_en_r   <= cpu_en_nxt_s;
            mode_cur_r <= mode_nxt_s;
            pending_r  <= change_s;
            if (cpu_en_r) begin
                tick_cnt_r <= tick_cnt_r + 32'd1;
            end else begin
                tick_cnt_r <= tick_cnt_r;
            end
        end
    end

    assign cpu_en   = cpu_en_r;
    assign mode_cur = mode_cur_r;
    assign pending  = pending_r;
    assign tick_cnt = tick_cnt_r;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with FAST_DIV=4, SLOW_DIV=10, DEB_CYCLES=4.
module tb_cpu_clk_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        step_btn;
    logic        cpu_en;
    logic [1:0]  mode_cur;
    logic        pending;
    logic [31:0] tick_cnt;

    int total = 0;
    int bad   = 0;

    cpu_clk_ctrl #(.FAST_DIV(4), .SLOW_DIV(10), .DEB_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .step_btn (step_btn),
        .cpu_en   (cpu_en),
        .mode_cur (mode_cur),
        .pending  (pending),
        .tick_cnt (tick_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One active edge, then sample on the following falling edge.
    task automatic step_clk();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        rst      = 1'b0;
        mode     = 2'b00;
        step_btn = 1'b0;
        step_clk();
        step_clk();
        chk("rst_en",   {31'd0, cpu_en},  32'd0);
        chk("rst_mode", {30'd0, mode_cur}, 32'd3);
        chk("rst_pend", {31'd0, pending}, 32'd0);
        chk("rst_tick", tick_cnt,         32'd0);

        // Power-up with fast requested: apply at edge 3, strobes every 4 edges.
        rst = 1'b1;
        step_clk();
        chk("pu_e1_mode", {30'd0, mode_cur}, 32'd3);
        chk("pu_e1_pend", {31'd0, pending},  32'd0);
        step_clk();
        chk("pu_e2_mode", {30'd0, mode_cur}, 32'd3);
        step_clk();
        chk("pu_e3_mode", {30'd0, mode_cur}, 32'd0);
        chk("pu_e3_pend", {31'd0, pending},  32'd1);
        for (int k = 1; k <= 12; k++) begin
            step_clk();
            chk("fast_en", {31'd0, cpu_en}, {31'd0, (k % 4) == 0});
            if (k == 1) chk("pu_pend_drop", {31'd0, pending}, 32'd0);
        end
        step_clk();
        chk("fast_tick3", tick_cnt, 32'd3);
        chk("fast_en_off", {31'd0, cpu_en}, 32'd0);

        // Fast to slow mid-period: period finishes, then a 10-cycle gap.
        mode = 2'b01;
        for (int n = 1; n <= 14; n++) begin
            step_clk();
            chk("f2s_en", {31'd0, cpu_en}, {31'd0, (n == 3) || (n == 13)});
            if (n == 2) chk("f2s_mode_old", {30'd0, mode_cur}, 32'd0);
            if (n == 3) chk("f2s_mode_new", {30'd0, mode_cur}, 32'd1);
        end
        chk("f2s_tick", tick_cnt, 32'd5);

        // Slow to step: applied at the next slow strobe.
        mode = 2'b10;
        repeat (15) step_clk();
        chk("step_mode", {30'd0, mode_cur}, 32'd2);
        chk("step_tick", tick_cnt, 32'd6);

        // Bouncy press: one strobe, 7 edges after the stable level begins.
        step_btn = 1'b1;
        step_clk();
        step_btn = 1'b0;
        step_clk();
        step_btn = 1'b1;
        for (int m = 1; m <= 12; m++) begin
            step_clk();
            chk("step_en", {31'd0, cpu_en}, {31'd0, m == 7});
        end
        chk("step_tick1", tick_cnt, 32'd7);

        // Press accepted in hold must not strobe after moving to step.
        mode = 2'b11;
        repeat (5) step_clk();
        chk("hold_mode", {30'd0, mode_cur}, 32'd3);
        step_btn = 1'b0;
        repeat (10) step_clk();
        step_btn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step_clk();
            if (cpu_en) pulses++;
        end
        mode = 2'b10;
        for (int i = 0; i < 12; i++) begin
            step_clk();
            if (cpu_en) pulses++;
        end
        chk("hold_step_mode", {30'd0, mode_cur}, 32'd2);
        chk("hold_step_pulses", pulses, 32'd0);
        chk("hold_step_tick", tick_cnt, 32'd7);

        // Wrap of tick_cnt from a preloaded value.
        mode = 2'b11;
        repeat (5) step_clk();
        force dut.tick_cnt_r = 32'hFFFF_FFFE;
        step_clk();
        release dut.tick_cnt_r;
        step_clk();
        chk("wrap_preload", tick_cnt, 32'hFFFF_FFFE);
        mode = 2'b00;
        for (int n = 1; n <= 12; n++) begin
            step_clk();
            chk("wrap_en", {31'd0, cpu_en}, {31'd0, (n == 7) || (n == 11)});
            chk("wrap_tick", tick_cnt,
                (n < 8) ? 32'hFFFF_FFFE : ((n < 12) ? 32'hFFFF_FFFF : 32'h0000_0000));
        end

        // Reset while the prescaler sits at 2 in fast mode.
        step_clk();
        chk("mid_presc", dut.presc_r, 32'd2);
        rst = 1'b0;
        #1;
        chk("mid_rst_en",   {31'd0, cpu_en},  32'd0);
        chk("mid_rst_mode", {30'd0, mode_cur}, 32'd3);
        chk("mid_rst_pend", {31'd0, pending}, 32'd0);
        chk("mid_rst_tick", tick_cnt,         32'd0);
        step_clk();
        rst = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step_clk();
            chk("mid_en", {31'd0, cpu_en}, {31'd0, n == 7});
            chk("mid_mode", {30'd0, mode_cur}, (n < 3) ? 32'd3 : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Glitch-free CPU clock-enable controller; the consuming end of the free-running divider chain.
- Replaces the raw combinational divided-clock mux with one-cycle `cpu_en` strobes, all in the single `clk` domain.
- Four modes: fast run, slow run, debounced single-step, and hold.
- Mode changes are applied only at strobe boundaries, so the CPU never sees a runt period.

Parameters:
- FAST_DIV, 4, `clk` cycles per `cpu_en` strobe in fast mode (legal range ≥2, ≤2^32-1).
- SLOW_DIV, 33554432, `clk` cycles per `cpu_en` strobe in slow mode (legal range ≥2).
- DEB_CYCLES, 65536, consecutive stable synchronized samples needed to accept a new button level (legal range ≥2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- mode  input  2  requested mode, asynchronous: 00 fast, 01 slow, 10 step, 11 hold.
- step_btn  input  1  raw single-step push-button, asynchronous and bouncy.
- cpu_en  output  1  one-`clk`-cycle CPU advance strobe.
- mode_cur  output  2  mode currently in effect.
- pending  output  1  synchronized requested mode differs from `mode_cur`.
- tick_cnt  output  32  count of `cpu_en` strobes issued.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - `cpu_en`=0, `tick_cnt`=0, `pending`=0.
  - `mode_cur`=11 (hold).
  - Prescaler=0, debounce counter=0, debounced level=0.
  - Both synchronizer chains cleared to 0.
- Synchronizers: `mode` and `step_btn` each pass through 2 flops; `mode_req` is the second flop of the `mode` chain.
- `pending` is registered: `pending` = (`mode_req` != `mode_cur`), updated every edge.
- Run modes (`mode_cur` 00 or 01), with D = FAST_DIV or SLOW_DIV:
  - 32-bit prescaler counts 0..D-1.
  - In the cycle the prescaler equals D-1: `cpu_en`=1 and the prescaler returns to 0.
  - First strobe comes D cycles after entering the mode; period is exactly D thereafter.
- Mode apply rule:
  - In run modes, a pending change is applied on the same edge that ends a strobe cycle (prescaler D-1 → 0). The strobe still occurs; `mode_cur` takes the new value; the prescaler restarts at 0.
  - In step or hold, a pending change is applied on the next edge.
  - Latency from hold: `mode` changes before edge 1 → `mode_req` valid after edge 2 → `mode_cur` updates at edge 3, with `pending` high for one cycle.
  - Only the latest `mode_req` is applied; intermediate requests are dropped.
- Debounce:
  - Synchronized button equals the debounced level → debounce counter cleared.
  - Otherwise the counter increments. When it reaches DEB_CYCLES-1 while still differing, the debounced level toggles and the counter clears.
  - Accept latency is DEB_CYCLES cycles of stable input after the synchronizer.
- Step mode (`mode_cur`=10): a rising edge of the debounced level produces `cpu_en`=1 for exactly the following cycle.
  - Falling edges are ignored.
  - Debounced edges in any other mode are ignored and not queued.
- Simultaneous events: if `pending`=1 in step mode in the cycle a debounced rising edge occurs, the mode change wins and the edge is discarded (no strobe).
- Hold (11): `cpu_en` stays 0, and the prescaler is held at 0.
- `tick_cnt` increments by 1 on every edge where `cpu_en`=1 and wraps from FFFFFFFF to 0.
- `cpu_en` is never asserted in two consecutive cycles in any mode.
- Reset mid-operation:
  - Any in-progress period, debounce or pending change is abandoned.
  - After release the block behaves as from power-up.
  - At least one full hold cycle occurs before any strobe.

Test Plan (FAST_DIV=4, SLOW_DIV=10, DEB_CYCLES=4):
- Reset release with `mode`=00 held → `mode_cur`=00 at edge 3. Strobes then appear on cycles 4, 8, 12 after the apply edge; `tick_cnt`=3 after the third strobe.
- In fast mode, switch `mode` to 01 mid-period → current period finishes with its strobe, `mode_cur`=01 on that edge, next strobe exactly 10 cycles later, no shorter gap anywhere.
- Step mode, `step_btn` bounces 0/1/0/1 at 1-cycle spacing then holds 1 for 10 cycles → exactly one `cpu_en` pulse, issued 2+4+1 cycles after the stable level begins.
- Button pressed in hold mode, then `mode` set to step → no strobe, `tick_cnt` unchanged.
- Preload `tick_cnt`=FFFFFFFE (force) and run fast mode → values FFFFFFFF then 00000000 on successive strobes.
- Assert `rst`=0 in the cycle the prescaler equals 2 in fast mode → `cpu_en`=0 and all outputs at reset values immediately, `mode_cur`=11. After release, first strobe 3+4 cycles later.
